// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue path: field positions, opcodes,
// flag indices and the issue FSM state encoding.
package alu_pkg;

  localparam int DATA_W  = 8;
  localparam int INSTR_W = 16;
  localparam int NREGS   = 4;
  localparam int REG_AW  = 2;
  localparam int FLAG_W  = 3;

  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 10;
  localparam int RS_MSB  = 9;
  localparam int RS_LSB  = 8;
  localparam int RT_MSB  = 7;
  localparam int RT_LSB  = 6;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;
  // op[3] separates register-register from register-immediate forms
  localparam int RTYPE_BIT = 15;

  localparam logic [3:0] OP_ILL0 = 4'b0000;
  localparam logic [3:0] OP_ADDI = 4'b0001;
  localparam logic [3:0] OP_SUBI = 4'b0010;
  localparam logic [3:0] OP_ANDI = 4'b0011;
  localparam logic [3:0] OP_ORI  = 4'b0100;
  localparam logic [3:0] OP_XORI = 4'b0101;
  localparam logic [3:0] OP_LLSI = 4'b0110;
  localparam logic [3:0] OP_LRSI = 4'b0111;
  localparam logic [3:0] OP_ADD  = 4'b1000;
  localparam logic [3:0] OP_SUB  = 4'b1001;
  localparam logic [3:0] OP_MUL  = 4'b1010;
  localparam logic [3:0] OP_AND  = 4'b1011;
  localparam logic [3:0] OP_OR   = 4'b1100;
  localparam logic [3:0] OP_LLS  = 4'b1101;
  localparam logic [3:0] OP_ILL1 = 4'b1110;
  localparam logic [3:0] OP_LRS  = 4'b1111;

  localparam int FLAG_N = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  function automatic logic op_is_legal(input logic [3:0] op);
    return !((op == OP_ILL0) || (op == OP_ILL1));
  endfunction

endpackage

// File: rtl/regfile4x8.sv
// Four 8-bit general-purpose registers: two operand read ports, one debug
// read port and a single synchronous write port; all clear on reset.
module regfile4x8
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] i_ra_addr,
  output logic [DATA_W-1:0] o_ra_data,
  input  logic [REG_AW-1:0] i_rb_addr,
  output logic [DATA_W-1:0] o_rb_data,
  input  logic [REG_AW-1:0] i_dbg_addr,
  output logic [DATA_W-1:0] o_dbg_data,
  input  logic              i_we,
  input  logic [REG_AW-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata
);

  logic [DATA_W-1:0] r_mem [NREGS];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_ra_data  = r_mem[i_ra_addr];
  assign o_rb_data  = r_mem[i_rb_addr];
  assign o_dbg_data = r_mem[i_dbg_addr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue/writeback controller for the external combinational ALU: accepts one
// instruction, drives op/A/B for one cycle, commits result and flags.
module alu_issue_ctrl
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [15:0] instr,
  output logic [3:0]  alu_op,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  input  logic [7:0]  alu_r,
  input  logic [2:0]  alu_flags,
  output logic [2:0]  flags_q,
  output logic        done,
  output logic        illegal,
  input  logic [1:0]  dbg_sel,
  output logic [7:0]  dbg_data
);

  // Handshake: a word transfers on a rising edge where instr_valid && instr_ready;
  // instr_ready comes only from the state register and rst_n, never from instr_valid.

  state_t              r_state;
  state_t              w_next_state;
  logic [REG_AW-1:0]   r_rd;
  logic                r_illegal;
  logic [3:0]          r_alu_op;
  logic [DATA_W-1:0]   r_alu_a;
  logic [DATA_W-1:0]   r_alu_b;
  logic [FLAG_W-1:0]   r_flags;

  logic                w_ready;
  logic                w_accept;
  logic                w_commit;
  logic                w_done;
  logic                w_illegal;
  logic [3:0]          w_op;
  logic                w_rtype;
  logic                w_op_legal;
  logic [REG_AW-1:0]   w_rd;
  logic [REG_AW-1:0]   w_rs;
  logic [REG_AW-1:0]   w_rt;
  logic [DATA_W-1:0]   w_imm;
  logic [DATA_W-1:0]   w_rs_data;
  logic [DATA_W-1:0]   w_rt_data;
  logic [DATA_W-1:0]   w_b_sel;

  assign w_op       = instr[OP_MSB:OP_LSB];
  assign w_rtype    = instr[RTYPE_BIT];
  assign w_rd       = instr[RD_MSB:RD_LSB];
  assign w_rs       = instr[RS_MSB:RS_LSB];
  assign w_rt       = instr[RT_MSB:RT_LSB];
  assign w_imm      = instr[IMM_MSB:IMM_LSB];
  assign w_op_legal = op_is_legal(w_op);
  assign w_b_sel    = w_rtype ? w_rt_data : w_imm;
  assign w_accept   = instr_valid && w_ready;

  regfile4x8 u_regfile (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_ra_addr  (w_rs),
    .o_ra_data  (w_rs_data),
    .i_rb_addr  (w_rt),
    .o_rb_data  (w_rt_data),
    .i_dbg_addr (dbg_sel),
    .o_dbg_data (dbg_data),
    .i_we       (w_commit),
    .i_waddr    (r_rd),
    .i_wdata    (alu_r)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_ready      = 1'b0;
    w_commit     = 1'b0;
    w_done       = 1'b0;
    w_illegal    = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        w_ready = rst_n;
        if (instr_valid && rst_n) begin
          w_next_state = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        w_commit     = !r_illegal;
        w_next_state = ST_DONE;
      end
      ST_DONE: begin
        w_done       = 1'b1;
        w_illegal    = r_illegal;
        w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // ALU inputs are loaded on accept and cleared on the following edge, so
  // they are non-zero only while in ISSUE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rd      <= '0;
      r_illegal <= 1'b0;
      r_alu_op  <= OP_ILL0;
      r_alu_a   <= '0;
      r_alu_b   <= '0;
    end else if (w_accept) begin
      r_rd      <= w_rd;
      r_illegal <= !w_op_legal;
      r_alu_op  <= w_op_legal ? w_op : OP_ILL0;
      r_alu_a   <= w_rs_data;
      r_alu_b   <= w_b_sel;
    end else begin
      r_alu_op  <= OP_ILL0;
      r_alu_a   <= '0;
      r_alu_b   <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_flags <= '0;
    end else if (w_commit) begin
      r_flags <= alu_flags;
    end
  end

  assign instr_ready = w_ready;
  assign alu_op      = r_alu_op;
  assign alu_a       = r_alu_a;
  assign alu_b       = r_alu_b;
  assign flags_q     = r_flags;
  assign done        = w_done;
  assign illegal     = w_illegal;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural ALU; stimulus pushes
// expectations, a monitor pops them at ISSUE and at retirement.
module tb_alu_issue_ctrl;

  localparam int W  = 14;  // {illegal, flags[2:0], rd[1:0], value[7:0]}
  localparam int OW = 21;  // {check_ab, op[3:0], a[7:0], b[7:0]}

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic [3:0]  alu_op;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [7:0]  alu_r;
  logic [2:0]  alu_flags;
  logic [2:0]  flags_q;
  logic        done;
  logic        illegal;
  logic [1:0]  dbg_sel;
  logic [7:0]  dbg_data;

  logic [W-1:0]  exp_q[$];
  logic [OW-1:0] op_q[$];
  int            n_checks = 0;
  int            n_pass   = 0;
  logic          stim_end    = 1'b0;
  logic          end_checked = 1'b0;

  alu_issue_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .alu_op      (alu_op),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_r       (alu_r),
    .alu_flags   (alu_flags),
    .flags_q     (flags_q),
    .done        (done),
    .illegal     (illegal),
    .dbg_sel     (dbg_sel),
    .dbg_data    (dbg_data)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- behavioural ALU ----------------
  logic [15:0] alu_prod;
  logic        alu_v;
  always_comb begin
    alu_r    = 8'h00;
    alu_v    = 1'b0;
    alu_prod = alu_a * alu_b;
    case (alu_op)
      4'h1, 4'h8: begin
        alu_r = alu_a + alu_b;
        alu_v = (alu_a[7] == alu_b[7]) && (alu_r[7] != alu_a[7]);
      end
      4'h2, 4'h9: begin
        alu_r = alu_a - alu_b;
        alu_v = (alu_a[7] != alu_b[7]) && (alu_r[7] != alu_a[7]);
      end
      4'hA:       alu_r = alu_prod[7:0];
      4'h3, 4'hB: alu_r = alu_a & alu_b;
      4'h4, 4'hC: alu_r = alu_a | alu_b;
      4'h5:       alu_r = alu_a ^ alu_b;
      4'h6, 4'hD: alu_r = alu_a << alu_b[2:0];
      4'h7, 4'hF: alu_r = alu_a >> alu_b[2:0];
      default:    alu_r = 8'h00;
    endcase
    alu_flags = {alu_r[7], (alu_r == 8'h00), alu_v};
  end

  // ---------------- scoreboard compare ----------------
  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // ---------------- driver ----------------
  task automatic send(input logic [15:0] w, input logic [3:0] op, input logic [7:0] a,
                      input logic [7:0] b, input logic ab_chk, input logic retires,
                      input logic ill, input logic [2:0] fl, input logic [1:0] rd,
                      input logic [7:0] val, input logic keep_valid);
    int n;
    @(negedge clk);
    instr       = w;
    instr_valid = 1'b1;
    n = 0;
    while (!instr_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!instr_ready) begin
      $display("FAIL accept_timeout: instr %h got no ready, required ready within 20 cycles", w);
      $fatal(1, "bench stalled");
    end
    op_q.push_back({ab_chk, op, a, b});
    if (retires) exp_q.push_back({ill, fl, rd, val});
    @(posedge clk);
    #1;
    if (!keep_valid) instr_valid = 1'b0;
  endtask

  // ---------------- monitor ----------------
  initial begin : monitor
    logic          pend_accept;
    logic          done_due;
    logic          prev_rst;
    logic          after_done;
    logic [W-1:0]  e;
    logic [OW-1:0] o;
    pend_accept = 1'b0;
    done_due    = 1'b0;
    prev_rst    = 1'b0;
    after_done  = 1'b0;
    dbg_sel     = 2'd0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) chk("ready_in_reset", 16'(instr_ready), 16'h0);
      if (prev_rst) begin
        chk("reset_done", 16'(done), 16'h0);
        chk("reset_alu_ab", {alu_a, alu_b}, 16'h0);
        chk("reset_op_flags_ill", 16'({alu_op, flags_q, illegal}), 16'h0);
        if (rst_n) chk("ready_after_reset", 16'(instr_ready), 16'h1);
        done_due    = 1'b0;
        pend_accept = 1'b0;
      end else begin
        if (after_done && rst_n) chk("ready_back_in_idle", 16'(instr_ready), 16'h1);
        if (done_due) chk("done_latency", 16'(done), 16'h1);
        if (pend_accept) begin
          if (op_q.size() == 0) begin
            chk("issue_expected", 16'(op_q.size()), 16'h1);
          end else begin
            o = op_q.pop_front();
            chk("issue_op", 16'(alu_op), 16'(o[19:16]));
            if (o[20]) chk("issue_ab", {alu_a, alu_b}, o[15:0]);
            chk("issue_ready_low", 16'(instr_ready), 16'h0);
            chk("issue_no_done", 16'(done), 16'h0);
          end
        end
        if (done) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_done", 16'(exp_q.size()), 16'h1);
          end else begin
            e = exp_q.pop_front();
            chk("illegal", 16'(illegal), 16'(e[13]));
            chk("flags_q", 16'(flags_q), 16'(e[12:10]));
            chk("done_ready_low", 16'(instr_ready), 16'h0);
            chk("done_alu_idle", {alu_a, alu_b}, 16'h0);
            dbg_sel = e[9:8];
            #1;
            chk("reg_writeback", 16'(dbg_data), 16'(e[7:0]));
          end
        end else if (illegal) begin
          chk("illegal_without_done", 16'(illegal), 16'h0);
        end
      end
      after_done  = done && rst_n;
      done_due    = pend_accept && rst_n;
      pend_accept = instr_valid && instr_ready && rst_n;
      prev_rst    = !rst_n;
      if (stim_end && !end_checked) begin
        chk("exp_q_drained", 16'(exp_q.size()), 16'h0);
        chk("op_q_drained", 16'(op_q.size()), 16'h0);
        end_checked = 1'b1;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin : stim
    rst_n       = 1'b0;
    instr_valid = 1'b0;
    instr       = 16'h0000;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    //    word      op    a      b      chkab ret  ill  flags   rd    value  keep
    send(16'h1405, 4'h1, 8'h00, 8'h05, 1'b1, 1'b1, 1'b0, 3'b000, 2'd1, 8'h05, 1'b0); // ADDI r1,r0,5
    send(16'h9940, 4'h9, 8'h05, 8'h05, 1'b1, 1'b1, 1'b0, 3'b010, 2'd2, 8'h00, 1'b0); // SUB r2,r1,r1
    send(16'h1C7F, 4'h1, 8'h00, 8'h7F, 1'b1, 1'b1, 1'b0, 3'b000, 2'd3, 8'h7F, 1'b0); // ADDI r3,r0,7F
    send(16'h1F01, 4'h1, 8'h7F, 8'h01, 1'b1, 1'b1, 1'b0, 3'b101, 2'd3, 8'h80, 1'b0); // ADDI r3,r3,1
    send(16'h1410, 4'h1, 8'h00, 8'h10, 1'b1, 1'b1, 1'b0, 3'b000, 2'd1, 8'h10, 1'b0); // ADDI r1,r0,10
    send(16'hA140, 4'hA, 8'h10, 8'h10, 1'b1, 1'b1, 1'b0, 3'b010, 2'd0, 8'h00, 1'b0); // MUL r0,r1,r1
    send(16'h1033, 4'h1, 8'h00, 8'h33, 1'b1, 1'b1, 1'b0, 3'b000, 2'd0, 8'h33, 1'b0); // ADDI r0,r0,33
    send(16'h1B00, 4'h1, 8'h80, 8'h00, 1'b1, 1'b1, 1'b0, 3'b100, 2'd2, 8'h80, 1'b0); // ADDI r2,r3,0
    send(16'hE000, 4'h0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 3'b100, 2'd0, 8'h33, 1'b0); // illegal 1110
    send(16'h0000, 4'h0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 3'b100, 2'd0, 8'h33, 1'b0); // illegal 0000
    send(16'h44C0, 4'h4, 8'h33, 8'hC0, 1'b1, 1'b1, 1'b0, 3'b100, 2'd1, 8'hF3, 1'b0); // ORI r1,r0,C0
    send(16'h59FF, 4'h5, 8'hF3, 8'hFF, 1'b1, 1'b1, 1'b0, 3'b000, 2'd2, 8'h0C, 1'b0); // XORI r2,r1,FF
    send(16'h6E02, 4'h6, 8'h0C, 8'h02, 1'b1, 1'b1, 1'b0, 3'b000, 2'd3, 8'h30, 1'b0); // LLSI r3,r2,2
    send(16'hB180, 4'hB, 8'hF3, 8'h0C, 1'b1, 1'b1, 1'b0, 3'b010, 2'd0, 8'h00, 1'b0); // AND r0,r1,r2

    // held valid: second word must wait for the next IDLE and go in once
    send(16'h1701, 4'h1, 8'h30, 8'h01, 1'b1, 1'b1, 1'b0, 3'b000, 2'd1, 8'h31, 1'b1); // ADDI r1,r3,1
    instr = 16'h2901;
    send(16'h2901, 4'h2, 8'h31, 8'h01, 1'b1, 1'b1, 1'b0, 3'b000, 2'd2, 8'h30, 1'b0); // SUBI r2,r1,1
    send(16'h7104, 4'h7, 8'h31, 8'h04, 1'b1, 1'b1, 1'b0, 3'b000, 2'd0, 8'h03, 1'b0); // LRSI r0,r1,4

    // reset while in ISSUE: no retirement expected
    send(16'h8180, 4'h8, 8'h31, 8'h30, 1'b1, 1'b0, 1'b0, 3'b000, 2'd0, 8'h00, 1'b0); // ADD r0,r1,r2
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    send(16'h8180, 4'h8, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 3'b010, 2'd0, 8'h00, 1'b0); // ADD r0,r1,r2
    send(16'h1F00, 4'h1, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 3'b010, 2'd3, 8'h00, 1'b0); // ADDI r3,r3,0

    repeat (6) @(negedge clk);
    stim_end = 1'b1;
    for (int i = 0; i < 10 && !end_checked; i++) @(negedge clk);
    if (!end_checked) begin
      n_checks++;
      $display("FAIL monitor_end: got no final drain check, required one within 10 cycles");
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
